round_timer: RTL and testbench
==============================

// Module: round_timer
// PURPOSE
//  Parametrised game-round timer for the whack-a-mole datapath: divides the system clock
//  into a TICK_HZ tick and runs a WIDTH-bit up/down round counter. Hold (one-shot) or wrap
//  (periodic) mode, start/restart, pause, done pulse and expired level. Drives the round
//  FSM and mole pop-up scheduler.
// PARAMETERS
//  CLK_HZ   50_000_000  system clock frequency
//  TICK_HZ  10          tick rate; DIV = CLK_HZ/TICK_HZ (localparam, must be >= 2)
//  WIDTH    8           round counter / limit width
// PORTS
//  clk        in   1      system clock, all logic on posedge
//  reset      in   1      synchronous, active-low (0 = reset); only reset, one clock domain
//  start      in   1      1-cycle pulse: latch limit/mode/dir, (re)start round from any state
//  pause      in   1      level: freeze prescaler and counter while 1
//  mode_wrap  in   1      sampled at start: 0 = hold at terminal, 1 = reload and continue
//  dir_down   in   1      sampled at start: 0 = count 0 -> limit, 1 = count limit -> 0
//  limit      in   WIDTH  sampled at start: terminal (up) or initial (down) value
//  tick       out  1      1-cycle pulse each DIV clks while RUN
//  count      out  WIDTH  current round value
//  running    out  1      1 in RUN or PAUSED
//  done       out  1      1-cycle pulse when terminal value is reached
//  expired    out  1      level, 1 in EXPIRED
// BEHAVIOUR
//  - Reset (reset==0 at posedge): state IDLE, prescaler 0, count 0, all outputs 0;
//    reset wins over start; reset mid-round aborts immediately.
//  - States: IDLE, RUN, PAUSED, EXPIRED.
//    IDLE -start-> RUN; RUN -pause-> PAUSED; PAUSED -!pause-> RUN;
//    RUN -terminal & hold-> EXPIRED; EXPIRED stays until start or reset.
//    start in any state -> RUN (restart); start has priority over pause that cycle.
//  - Start latency: start sampled at edge N; from N+1: RUN, prescaler 0,
//    count = 0 (up) or limit (down); first tick DIV clks later.
//  - Prescaler counts 0..DIV-1 only in RUN; tick=1 in the cycle prescaler==DIV-1,
//    prescaler wraps to 0 there. Held (not cleared) in PAUSED; cleared in IDLE/EXPIRED.
//  - On tick: count +1 (up) or -1 (down), modulo 2^WIDTH never reached (terminal first).
//    If the new value equals terminal (limit up / 0 down): done=1 on the following cycle
//    together with the new count; hold -> EXPIRED with count held at terminal;
//    wrap -> count reloads to start value on the next tick, stays RUN.
//  - Wrap semantic: terminal value is visible for one full tick period before reload.
//  - limit==0: hold -> EXPIRED and done pulse one cycle after RUN entry (no tick needed);
//    wrap -> count stays 0, done pulses on every tick.
//  - pause asserted the cycle a tick would occur: tick suppressed, count unchanged.
//  - running = (RUN|PAUSED); expired = EXPIRED; all outputs registered.
// STRUCTURE
//  - Shared package game_pkg: state encoding constants (IDLE/RUN/PAUSED/EXPIRED, 2-bit),
//    MODE_HOLD/MODE_WRAP, DIR_UP/DIR_DOWN.
//  - Sub-module tick_prescaler #(DIV): enable, clear -> tick; instantiated once.
//  - round_timer holds the FSM, latched limit/mode/dir and counter.
// TESTING  (bench uses CLK_HZ=40, TICK_HZ=10 -> DIV=4, WIDTH=4)
//  1 reset=0 for 3 clks with start=1 -> count=0, tick/done/expired/running=0.
//  2 start, up, hold, limit=3 -> tick every 4 clks; count 1,2,3; done once; expired=1,
//    count holds 3 for 20 clks with no further done.
//  3 start, down, wrap, limit=2 -> count 2,1,0 (done),2,1,0 (done); running stays 1.
//  4 up, limit=5, pause 6 clks after count=2 -> no tick/count change while paused;
//    resumes with same prescaler phase; total time to done = 20 + 6 clks.
//  5 restart: start again at count=4 (limit 9) -> next cycle count=0, prescaler 0;
//    reset=0 mid-round -> IDLE, count=0 next cycle.
//  6 limit=0: hold -> done + expired one cycle after RUN; wrap -> done every 4 clks.

Source files
------------

// File: rtl/game_pkg.sv
// Shared encodings for the whack-a-mole game datapath: round states and the
// mode/direction values sampled when a round starts.
package game_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSED  = 2'd2,
        EXPIRED = 2'd3
    } round_state_t;

    localparam logic MODE_HOLD = 1'b0;
    localparam logic MODE_WRAP = 1'b1;
    localparam logic DIR_UP    = 1'b0;
    localparam logic DIR_DOWN  = 1'b1;

endpackage

// File: rtl/tick_prescaler.sv
// Divides the system clock by DIV: while enabled, tick is high for the one
// cycle in which the internal phase counter sits at DIV-1.
module tick_prescaler #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int PW = $clog2(DIV);
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    logic [PW-1:0] phase;

    assign tick = enable && (phase == LAST);

    // clear outranks enable so a restart always begins on a fresh phase
    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            phase <= '0;
        end else if (enable) begin
            phase <= tick ? '0 : phase + PW'(1);
        end
    end

endmodule

// File: rtl/round_timer.sv
// Game-round timer: prescaled tick plus an up/down round counter with hold
// (one-shot) or wrap (periodic) behaviour, pause, done pulse and expired level.
module round_timer
    import game_pkg::*;
#(
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = 10,
    parameter int WIDTH   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             pause,
    input  logic             mode_wrap,
    input  logic             dir_down,
    input  logic [WIDTH-1:0] limit,
    output logic             tick,
    output logic [WIDTH-1:0] count,
    output logic             running,
    output logic             done,
    output logic             expired
);

    localparam int DIV = CLK_HZ / TICK_HZ;

    round_state_t     state, state_n;
    logic             mode_q, dir_q;
    logic [WIDTH-1:0] limit_q;
    logic [WIDTH-1:0] count_n, start_val, terminal;
    logic             tick_n, done_n;
    logic             active, presc_en, presc_clr, presc_tick;

    // The prescaler follows the pause level directly, so the transition cycle
    // out of PAUSED still advances and a pause of N clocks costs exactly N.
    assign active    = (state == RUN) || (state == PAUSED);
    assign presc_en  = active && !pause;
    assign presc_clr = start || !active;

    tick_prescaler #(.DIV(DIV)) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .enable (presc_en),
        .clear  (presc_clr),
        .tick   (presc_tick)
    );

    assign start_val = (dir_q == DIR_DOWN) ? limit_q : '0;
    assign terminal  = (dir_q == DIR_DOWN) ? '0 : limit_q;

    always_comb begin
        state_n = state;
        count_n = count;
        tick_n  = 1'b0;
        done_n  = 1'b0;
        if (start) begin
            state_n = RUN;
            count_n = (dir_down == DIR_DOWN) ? limit : '0;
        end else if (active) begin
            // only reachable with a zero-length hold round: expire without a tick
            if (mode_q == MODE_HOLD && count == terminal) begin
                state_n = EXPIRED;
                done_n  = 1'b1;
            end else begin
                state_n = pause ? PAUSED : RUN;
                if (presc_tick) begin
                    tick_n = 1'b1;
                    if (count == terminal) begin
                        count_n = start_val;
                    end else if (dir_q == DIR_DOWN) begin
                        count_n = count - WIDTH'(1);
                    end else begin
                        count_n = count + WIDTH'(1);
                    end
                    if (count_n == terminal) begin
                        done_n = 1'b1;
                        if (mode_q == MODE_HOLD) begin
                            state_n = EXPIRED;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            count   <= '0;
            tick    <= 1'b0;
            done    <= 1'b0;
            mode_q  <= MODE_HOLD;
            dir_q   <= DIR_UP;
            limit_q <= '0;
        end else begin
            state <= state_n;
            count <= count_n;
            tick  <= tick_n;
            done  <= done_n;
            if (start) begin
                mode_q  <= mode_wrap;
                dir_q   <= dir_down;
                limit_q <= limit;
            end
        end
    end

    assign running = active;
    assign expired = (state == EXPIRED);

endmodule

// File: tb/tb_round_timer.sv
// Directed bench for round_timer at DIV=4, WIDTH=4: a per-cycle vector table
// for reset/hold/wrap rounds plus hand sequences for pause, restart and limit 0.
module tb_round_timer;

    logic       clk = 1'b0;
    logic       reset, start, pause, mode_wrap, dir_down;
    logic [3:0] limit;
    logic       tick, running, done, expired;
    logic [3:0] count;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       rst_n, start, pause, wrap, down;
        logic [3:0] limit;
        logic [3:0] e_count;
        logic       e_tick, e_done, e_run, e_exp;
    } vec_t;

    vec_t vecs[$];

    round_timer #(.CLK_HZ(40), .TICK_HZ(10), .WIDTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .pause     (pause),
        .mode_wrap (mode_wrap),
        .dir_down  (dir_down),
        .limit     (limit),
        .tick      (tick),
        .count     (count),
        .running   (running),
        .done      (done),
        .expired   (expired)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input logic r, input logic s, input logic p,
                                 input logic w, input logic d, input logic [3:0] lim);
        reset     = r;
        start     = s;
        pause     = p;
        mode_wrap = w;
        dir_down  = d;
        limit     = lim;
    endtask

    task automatic checkOutput(input string name, input logic [3:0] c, input logic t,
                               input logic dn, input logic r, input logic e);
        checks++;
        if ({count, tick, done, running, expired} !== {c, t, dn, r, e}) begin
            failures++;
            $display("[TB] FAIL %s: got count=%0d tick=%0b done=%0b running=%0b expired=%0b, want count=%0d tick=%0b done=%0b running=%0b expired=%0b",
                     name, count, tick, done, running, expired, c, t, dn, r, e);
        end
    endtask

    task automatic addVec(input logic r, input logic s, input logic p, input logic w,
                          input logic d, input logic [3:0] lim, input logic [3:0] c,
                          input logic t, input logic dn, input logic run, input logic e,
                          input int rep);
        vec_t v;
        v.rst_n = r; v.start = s; v.pause = p; v.wrap = w; v.down = d; v.limit = lim;
        v.e_count = c; v.e_tick = t; v.e_done = dn; v.e_run = run; v.e_exp = e;
        for (int i = 0; i < rep; i++) vecs.push_back(v);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int done_cyc;
        logic pulse;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd3);

        // reset held with start high: everything stays cleared
        addVec(0, 1, 0, 0, 0, 3, 0, 0, 0, 0, 0, 3);
        // up, hold, limit 3; inputs change mid-round to show they were latched
        addVec(1, 1, 0, 0, 0, 3, 0, 0, 0, 1, 0, 1);
        addVec(1, 0, 0, 1, 1, 7, 0, 0, 0, 1, 0, 3);
        addVec(1, 0, 0, 1, 1, 7, 1, 1, 0, 1, 0, 1);
        addVec(1, 0, 0, 1, 1, 7, 1, 0, 0, 1, 0, 3);
        addVec(1, 0, 0, 1, 1, 7, 2, 1, 0, 1, 0, 1);
        addVec(1, 0, 0, 1, 1, 7, 2, 0, 0, 1, 0, 3);
        addVec(1, 0, 0, 1, 1, 7, 3, 1, 1, 0, 1, 1);
        addVec(1, 0, 0, 1, 1, 7, 3, 0, 0, 0, 1, 20);
        // down, wrap, limit 2: 2,1,0(done),2,1,0(done)
        addVec(1, 1, 0, 1, 1, 2, 2, 0, 0, 1, 0, 1);
        addVec(1, 0, 0, 0, 0, 9, 2, 0, 0, 1, 0, 3);
        addVec(1, 0, 0, 0, 0, 9, 1, 1, 0, 1, 0, 1);
        addVec(1, 0, 0, 0, 0, 9, 1, 0, 0, 1, 0, 3);
        addVec(1, 0, 0, 0, 0, 9, 0, 1, 1, 1, 0, 1);
        addVec(1, 0, 0, 0, 0, 9, 0, 0, 0, 1, 0, 3);
        addVec(1, 0, 0, 0, 0, 9, 2, 1, 0, 1, 0, 1);
        addVec(1, 0, 0, 0, 0, 9, 2, 0, 0, 1, 0, 3);
        addVec(1, 0, 0, 0, 0, 9, 1, 1, 0, 1, 0, 1);
        addVec(1, 0, 0, 0, 0, 9, 1, 0, 0, 1, 0, 3);
        addVec(1, 0, 0, 0, 0, 9, 0, 1, 1, 1, 0, 1);
        addVec(1, 0, 0, 0, 0, 9, 0, 0, 0, 1, 0, 3);

        @(negedge clk);
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst_n, vecs[i].start, vecs[i].pause,
                          vecs[i].wrap, vecs[i].down, vecs[i].limit);
            @(negedge clk);
            checkOutput($sformatf("vec%0d", i), vecs[i].e_count, vecs[i].e_tick,
                        vecs[i].e_done, vecs[i].e_run, vecs[i].e_exp);
        end

        // pause for 6 clocks right after count reaches 2 (up, hold, limit 5)
        applyStimulus(1, 1, 0, 0, 0, 5);
        @(negedge clk);
        done_cyc = -1;
        for (int cyc = 1; cyc <= 60 && done_cyc < 0; cyc++) begin
            applyStimulus(1, 0, (cyc >= 9 && cyc <= 14), 0, 0, 5);
            @(negedge clk);
            if (cyc == 8) checkOutput("pause_pre", 2, 1, 0, 1, 0);
            if (cyc >= 9 && cyc <= 15) checkOutput("pause_freeze", 2, 0, 0, 1, 0);
            if (cyc == 18) checkOutput("pause_resume_tick", 3, 1, 0, 1, 0);
            if (done) done_cyc = cyc;
        end
        checks++;
        if (done_cyc != 26) begin
            failures++;
            $display("[TB] FAIL pause_done_time: got %0d clks, want 26", done_cyc);
        end
        checkOutput("pause_final", 5, 1, 1, 0, 1);

        // restart mid-round with the prescaler part-way through its period
        applyStimulus(1, 1, 0, 0, 0, 9);
        @(negedge clk);
        for (int cyc = 1; cyc <= 18; cyc++) begin
            applyStimulus(1, 0, 0, 0, 0, 9);
            @(negedge clk);
        end
        checkOutput("restart_pre", 4, 0, 0, 1, 0);
        applyStimulus(1, 1, 0, 0, 0, 9);
        @(negedge clk);
        checkOutput("restart_clear", 0, 0, 0, 1, 0);
        for (int cyc = 1; cyc <= 4; cyc++) begin
            applyStimulus(1, 0, 0, 0, 0, 9);
            @(negedge clk);
            if (cyc < 4) checkOutput("restart_phase_wait", 0, 0, 0, 1, 0);
            else         checkOutput("restart_first_tick", 1, 1, 0, 1, 0);
        end
        applyStimulus(0, 0, 0, 0, 0, 9);
        @(negedge clk);
        checkOutput("midround_reset", 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 9);
        @(negedge clk);
        checkOutput("idle_after_reset", 0, 0, 0, 0, 0);

        // limit 0, hold: expires one cycle after entering RUN
        applyStimulus(1, 1, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("lim0_hold_entry", 0, 0, 0, 1, 0);
        applyStimulus(1, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("lim0_hold_done", 0, 0, 1, 0, 1);
        @(negedge clk);
        checkOutput("lim0_hold_stay", 0, 0, 0, 0, 1);

        // limit 0, wrap: done on every tick, count stays 0
        applyStimulus(1, 1, 0, 1, 0, 0);
        @(negedge clk);
        checkOutput("lim0_wrap_entry", 0, 0, 0, 1, 0);
        for (int cyc = 1; cyc <= 8; cyc++) begin
            applyStimulus(1, 0, 0, 1, 0, 0);
            @(negedge clk);
            pulse = ((cyc % 4) == 0);
            checkOutput($sformatf("lim0_wrap_c%0d", cyc), 0, pulse, pulse, 1, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
